branch_hazard_unit: RTL and testbench

//  Producer of the decode-stage forward selects consumed by the branch comparator. Also drives pipeline stall/flush control.

---
 rtl/pipeline_pkg.sv | 28 ++
 rtl/branch_hazard_unit_shadow_stage.sv | 27 ++
 rtl/branch_hazard_unit.sv | 167 ++++++++++++++++
 tb/tb_branch_hazard_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared forward-select codes and the shadow-pipeline entry layout used by the
// branch hazard unit and its shadow stages.
package pipeline_pkg;

  localparam int PKG_REG_W = 5;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;
  localparam logic [1:0] FWD_RSVD = 2'b11;

  typedef struct packed {
    logic                 valid;
    logic [PKG_REG_W-1:0] dst;
    logic                 regwrite;
    logic                 memtoreg;
  } shadow_entry_t;

  localparam int SHADOW_W = $bits(shadow_entry_t);

  localparam shadow_entry_t SHADOW_BUBBLE = '{
    valid:    1'b0,
    dst:      {PKG_REG_W{1'b0}},
    regwrite: 1'b0,
    memtoreg: 1'b0
  };

endpackage

// File: rtl/branch_hazard_unit_shadow_stage.sv
// One shadow pipeline register: freezes on hold, inserts an invalid entry on
// bubble, otherwise captures the entry presented on load.
module hazard_shadow_stage
  import pipeline_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          hold,
  input  logic          bubble,
  input  shadow_entry_t load,
  output shadow_entry_t entry
);

  // Shadow entry register; hold wins over bubble so a frozen pipe keeps its bubble decision pending
  always_ff @(posedge clk) begin
    if (rst) begin
      entry <= SHADOW_BUBBLE;
    end else if (hold) begin
      entry <= entry;
    end else if (bubble) begin
      entry <= SHADOW_BUBBLE;
    end else begin
      entry <= load;
    end
  end

endmodule

// File: rtl/branch_hazard_unit.sv
// Decode-stage branch forwarding and stall/flush control from a private EX/MEM/WB
// shadow pipeline. Define HAZ_MD_EN to add the mult/div busy interlock.
module branch_hazard_unit
  import pipeline_pkg::*;
#(
  parameter int REG_W      = PKG_REG_W,
  parameter int MD_LATENCY = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic             use_rs_d,
  input  logic             use_rt_d,
  input  logic             branch_d,
  input  logic [REG_W-1:0] dst_d,
  input  logic             regwrite_d,
  input  logic             memtoreg_d,
  input  logic             ext_stall,
  input  logic             md_start_d,
  input  logic             md_read_d,
  output logic [1:0]       fwd_a_d,
  output logic [1:0]       fwd_b_d,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_e,
  output logic             md_busy
);

  shadow_entry_t id_entry_s;
  shadow_entry_t ex_r;
  shadow_entry_t mem_r;
  shadow_entry_t wb_r;

  logic       haz_rs_s;
  logic       haz_rt_s;
  logic       md_busy_s;
  logic       md_stall_s;
  logic       stall_s;
  logic [1:0] fwd_a_s;
  logic [1:0] fwd_b_s;

  function automatic logic stage_match(input shadow_entry_t e, input logic [REG_W-1:0] src);
    return e.valid && e.regwrite && (e.dst == src) && (src != {REG_W{1'b0}});
  endfunction

  // Loads stall any reader in EX; branches compare in ID so also wait on EX ALU and MEM loads.
  function automatic logic src_hazard(input logic used, input logic [REG_W-1:0] src,
                                      input logic is_branch, input shadow_entry_t ex,
                                      input shadow_entry_t mem);
    logic ex_hit;
    logic mem_load_hit;
    ex_hit       = stage_match(ex, src);
    mem_load_hit = stage_match(mem, src) && mem.memtoreg;
    if (!used) begin
      return 1'b0;
    end else begin
      return (ex_hit && ex.memtoreg) || (is_branch && (ex_hit || mem_load_hit));
    end
  endfunction

  function automatic logic [1:0] src_fwd(input logic used, input logic [REG_W-1:0] src,
                                         input shadow_entry_t mem, input shadow_entry_t wb);
    if (!used) begin
      return FWD_RF;
    end else if (stage_match(mem, src) && !mem.memtoreg) begin
      return FWD_MEM;
    end else if (stage_match(wb, src)) begin
      return FWD_WB;
    end else begin
      return FWD_RF;
    end
  endfunction

  assign id_entry_s = '{
    valid:    1'b1,
    dst:      dst_d,
    regwrite: regwrite_d,
    memtoreg: memtoreg_d
  };

  // Hazard detection and raw forward selects from the current shadow state
  always_comb begin
    haz_rs_s = src_hazard(use_rs_d, rs_d, branch_d, ex_r, mem_r);
    haz_rt_s = src_hazard(use_rt_d, rt_d, branch_d, ex_r, mem_r);
    fwd_a_s  = src_fwd(use_rs_d, rs_d, mem_r, wb_r);
    fwd_b_s  = src_fwd(use_rt_d, rt_d, mem_r, wb_r);
    stall_s  = haz_rs_s || haz_rt_s || md_stall_s;
  end

`ifdef HAZ_MD_EN
  localparam int MD_CNT_W = $clog2(MD_LATENCY + 1);

  logic [MD_CNT_W-1:0] md_count_r;

  // Busy countdown: reloads on an accepted issue, otherwise drains while the pipe moves
  always_ff @(posedge clk) begin
    if (rst) begin
      md_count_r <= {MD_CNT_W{1'b0}};
    end else if (ext_stall) begin
      md_count_r <= md_count_r;
    end else if (md_start_d && !stall_s) begin
      md_count_r <= MD_CNT_W'(MD_LATENCY);
    end else if (md_count_r != {MD_CNT_W{1'b0}}) begin
      md_count_r <= md_count_r - MD_CNT_W'(1);
    end else begin
      md_count_r <= md_count_r;
    end
  end

  assign md_busy_s  = (md_count_r != {MD_CNT_W{1'b0}});
  assign md_stall_s = md_busy_s && (md_read_d || md_start_d);
`else
  logic unused_md_s;

  assign unused_md_s = md_start_d ^ md_read_d ^ (MD_LATENCY > 0);
  assign md_busy_s   = 1'b0;
  assign md_stall_s  = 1'b0;
`endif

  // Output gating: quiet during reset, selects only meaningful when not stalled
  always_comb begin
    if (rst) begin
      fwd_a_d = FWD_RF;
      fwd_b_d = FWD_RF;
      stall_f = 1'b0;
      stall_d = 1'b0;
      flush_e = 1'b0;
      md_busy = 1'b0;
    end else begin
      fwd_a_d = stall_s ? FWD_RF : fwd_a_s;
      fwd_b_d = stall_s ? FWD_RF : fwd_b_s;
      stall_f = stall_s;
      stall_d = stall_s;
      flush_e = stall_s && !ext_stall;
      md_busy = md_busy_s;
    end
  end

  hazard_shadow_stage u_ex (
    .clk    (clk),
    .rst    (rst),
    .hold   (ext_stall),
    .bubble (stall_s),
    .load   (id_entry_s),
    .entry  (ex_r)
  );

  hazard_shadow_stage u_mem (
    .clk    (clk),
    .rst    (rst),
    .hold   (ext_stall),
    .bubble (1'b0),
    .load   (ex_r),
    .entry  (mem_r)
  );

  hazard_shadow_stage u_wb (
    .clk    (clk),
    .rst    (rst),
    .hold   (ext_stall),
    .bubble (1'b0),
    .load   (mem_r),
    .entry  (wb_r)
  );

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Self-checking bench for branch_hazard_unit: directed scenarios plus random
// traffic compared every cycle against an instruction-history reference model.
module tb_branch_hazard_unit;

  localparam int REG_W      = 5;
  localparam int MD_LATENCY = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] rs_d, rt_d, dst_d;
  logic             use_rs_d, use_rt_d, branch_d, regwrite_d, memtoreg_d;
  logic             ext_stall, md_start_d, md_read_d;
  logic [1:0]       fwd_a_d, fwd_b_d;
  logic             stall_f, stall_d, flush_e, md_busy;

  always #5 clk = ~clk;

  branch_hazard_unit #(.REG_W(REG_W), .MD_LATENCY(MD_LATENCY)) dut (
    .clk(clk), .rst(rst), .rs_d(rs_d), .rt_d(rt_d), .use_rs_d(use_rs_d), .use_rt_d(use_rt_d),
    .branch_d(branch_d), .dst_d(dst_d), .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d),
    .ext_stall(ext_stall), .md_start_d(md_start_d), .md_read_d(md_read_d),
    .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d), .stall_f(stall_f), .stall_d(stall_d),
    .flush_e(flush_e), .md_busy(md_busy)
  );

  // Reference: history of instructions that left ID; index 0 is the one now in EX.
  typedef struct { bit valid; int dst; bit rw; bit ld; } ins_t;
  ins_t pipe[$];
  int   adv_cnt = 0;
  int   md_end  = 0;
  int   n_cmp   = 0;
  int   n_bad   = 0;

  function automatic bit hit(int d, int src);
    if (d >= pipe.size()) return 1'b0;
    return pipe[d].valid && pipe[d].rw && (pipe[d].dst == src) && (src != 0);
  endfunction

  function automatic bit src_stall(bit used, int src);
    if (!used) return 1'b0;
    if (hit(0, src) && pipe[0].ld) return 1'b1;
    if (branch_d && hit(0, src)) return 1'b1;
    if (branch_d && hit(1, src) && pipe[1].ld) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int src_fwd(bit used, int src);
    if (!used) return 0;
    if (hit(1, src) && !pipe[1].ld) return 2;
    if (hit(2, src)) return 1;
    return 0;
  endfunction

  function automatic bit model_busy();
`ifdef HAZ_MD_EN
    return adv_cnt < md_end;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit model_stall();
    return src_stall(use_rs_d, int'(rs_d)) || src_stall(use_rt_d, int'(rt_d)) ||
           (model_busy() && (md_start_d || md_read_d));
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    bit st;
    st = model_stall();
    if (rst) begin
      chk("rst_stall_f", int'(stall_f), 0);
      chk("rst_stall_d", int'(stall_d), 0);
      chk("rst_flush_e", int'(flush_e), 0);
      chk("rst_md_busy", int'(md_busy), 0);
      chk("rst_fwd_a",   int'(fwd_a_d), 0);
      chk("rst_fwd_b",   int'(fwd_b_d), 0);
    end else begin
      chk("stall_f", int'(stall_f), int'(st));
      chk("stall_d", int'(stall_d), int'(st));
      chk("flush_e", int'(flush_e), int'(st && !ext_stall));
      chk("md_busy", int'(md_busy), int'(model_busy()));
      if (!st) begin
        chk("fwd_a", int'(fwd_a_d), src_fwd(use_rs_d, int'(rs_d)));
        chk("fwd_b", int'(fwd_b_d), src_fwd(use_rt_d, int'(rt_d)));
      end
    end
  endtask

  task automatic model_update();
    bit   st;
    ins_t e;
    if (rst) begin
      pipe.delete();
      e = '{valid: 1'b0, dst: 0, rw: 1'b0, ld: 1'b0};
      repeat (3) pipe.push_back(e);
      adv_cnt = 0;
      md_end  = 0;
    end else if (!ext_stall) begin
      st = model_stall();
      if (st) e = '{valid: 1'b0, dst: 0, rw: 1'b0, ld: 1'b0};
      else    e = '{valid: 1'b1, dst: int'(dst_d), rw: regwrite_d, ld: memtoreg_d};
      pipe.push_front(e);
      e = pipe.pop_back();
`ifdef HAZ_MD_EN
      if (md_start_d && !st) md_end = adv_cnt + 1 + MD_LATENCY;
`endif
      adv_cnt++;
    end
  endtask

  task automatic instr(int rs, int rt, bit urs, bit urt, bit br, int dst, bit rw, bit ld);
    rs_d = REG_W'(rs); rt_d = REG_W'(rt); use_rs_d = urs; use_rt_d = urt; branch_d = br;
    dst_d = REG_W'(dst); regwrite_d = rw; memtoreg_d = ld;
    ext_stall = 1'b0; md_start_d = 1'b0; md_read_d = 1'b0;
  endtask

  task automatic begin_cyc();
    #2;
    model_compare();
  endtask

  task automatic end_cyc();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic nop();
    instr(0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    begin_cyc();
    end_cyc();
  endtask

  task automatic drain();
    repeat (3) nop();
  endtask

  initial begin
    rst = 1'b1;
    instr(3, 3, 1'b1, 1'b1, 1'b1, 3, 1'b1, 1'b1);
    @(negedge clk);
    repeat (2) begin
      begin_cyc();
      chk("reset_stall", int'(stall_f), 0);
      end_cyc();
    end
    rst = 1'b0;
    begin_cyc();
    chk("post_reset_fwd_a", int'(fwd_a_d), 0);
    end_cyc();
    drain();

    // ALU producer feeding a branch: one stall, then MEM forward
    instr(0, 0, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b0); begin_cyc(); end_cyc();
    instr(3, 4, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0); begin_cyc();
    chk("alu_br_stall", int'(stall_f), 1); chk("alu_br_flush", int'(flush_e), 1); end_cyc();
    instr(3, 4, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0); begin_cyc();
    chk("alu_br_go", int'(stall_d), 0); chk("alu_br_fwd_a", int'(fwd_a_d), 2);
    chk("alu_br_fwd_b", int'(fwd_b_d), 0); end_cyc();
    drain();

    // Load feeding a branch: two stalls, then WB forward
    instr(0, 0, 1'b0, 1'b0, 1'b0, 5, 1'b1, 1'b1); begin_cyc(); end_cyc();
    for (int i = 0; i < 2; i++) begin
      instr(5, 0, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0); begin_cyc();
      chk("ld_br_stall", int'(stall_f), 1); end_cyc();
    end
    instr(5, 0, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0); begin_cyc();
    chk("ld_br_go", int'(stall_f), 0); chk("ld_br_fwd_a", int'(fwd_a_d), 1);
    chk("ld_br_fwd_b", int'(fwd_b_d), 0); end_cyc();
    drain();

    // Load-use on an ALU op: exactly one stall
    instr(0, 0, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b1); begin_cyc(); end_cyc();
    instr(2, 2, 1'b1, 1'b1, 1'b0, 7, 1'b1, 1'b0); begin_cyc();
    chk("lu_stall", int'(stall_f), 1); chk("lu_flush", int'(flush_e), 1); end_cyc();
    instr(2, 2, 1'b1, 1'b1, 1'b0, 7, 1'b1, 1'b0); begin_cyc();
    chk("lu_go", int'(stall_f), 0); end_cyc();
    drain();

    // Same register in MEM and WB: MEM wins
    instr(0, 0, 1'b0, 1'b0, 1'b0, 6, 1'b1, 1'b0); begin_cyc(); end_cyc();
    instr(0, 0, 1'b0, 1'b0, 1'b0, 6, 1'b1, 1'b0); begin_cyc(); end_cyc();
    nop();
    instr(6, 6, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0); begin_cyc();
    chk("prio_stall", int'(stall_f), 0); chk("prio_fwd_a", int'(fwd_a_d), 2);
    chk("prio_fwd_b", int'(fwd_b_d), 2); end_cyc();
    drain();

    // External stall during a load-branch stall keeps the remaining count
    instr(0, 0, 1'b0, 1'b0, 1'b0, 5, 1'b1, 1'b1); begin_cyc(); end_cyc();
    for (int i = 0; i < 3; i++) begin
      instr(5, 5, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0); ext_stall = 1'b1; begin_cyc();
      chk("ext_stall_hold", int'(stall_f), 1); chk("ext_flush_off", int'(flush_e), 0); end_cyc();
    end
    for (int i = 0; i < 2; i++) begin
      instr(5, 5, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0); begin_cyc();
      chk("ext_resume_stall", int'(stall_f), 1); chk("ext_resume_flush", int'(flush_e), 1); end_cyc();
    end
    instr(5, 5, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0); begin_cyc();
    chk("ext_release_go", int'(stall_f), 0); chk("ext_release_fwd", int'(fwd_a_d), 1); end_cyc();
    drain();

    // Reset during a stall aborts it
    instr(0, 0, 1'b0, 1'b0, 1'b0, 4, 1'b1, 1'b1); begin_cyc(); end_cyc();
    instr(4, 0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b0); begin_cyc();
    chk("pre_rst_stall", int'(stall_f), 1); end_cyc();
    rst = 1'b1; begin_cyc(); chk("rst_mid_stall", int'(stall_f), 0); end_cyc();
    rst = 1'b0; begin_cyc(); chk("rst_abort_stall", int'(stall_f), 0); end_cyc();
    drain();

`ifdef HAZ_MD_EN
    // mult then mfhi: stall for the full busy window
    instr(0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0); md_start_d = 1'b1; begin_cyc(); end_cyc();
    for (int i = 0; i < MD_LATENCY; i++) begin
      instr(0, 0, 1'b0, 1'b0, 1'b0, 8, 1'b1, 1'b0); md_read_d = 1'b1; begin_cyc();
      chk("md_read_stall", int'(stall_f), 1); chk("md_busy_on", int'(md_busy), 1); end_cyc();
    end
    instr(0, 0, 1'b0, 1'b0, 1'b0, 8, 1'b1, 1'b0); md_read_d = 1'b1; begin_cyc();
    chk("md_read_go", int'(stall_f), 0); chk("md_busy_off", int'(md_busy), 0); end_cyc();
    instr(0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0); md_start_d = 1'b1; begin_cyc(); end_cyc();
    nop();
    rst = 1'b1; nop();
    rst = 1'b0; begin_cyc(); chk("md_rst_clear", int'(md_busy), 0); end_cyc();
`endif

    // Random traffic on a small register set to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      instr(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            1'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom_range(0, 2) == 0));
      ext_stall  = ($urandom_range(0, 7) == 0);
      md_start_d = ($urandom_range(0, 9) == 0);
      md_read_d  = ($urandom_range(0, 5) == 0);
      begin_cyc();
      end_cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
